// File: rtl/gnn_pkg.sv
// Shared types and helpers for the dnn output-side blocks.
package gnn_pkg;

    localparam int unsigned DATA_W = 21;

    typedef logic signed [DATA_W-1:0] lane_t;
    // Packed so that lane 0 sits in the LSBs of the flattened word.
    typedef lane_t [3:0] vec4_t;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDrain,
        StDone
    } wb_state_e;

    // Optional ReLU clamp followed by an arithmetic right shift.
    function automatic lane_t wb_act(input lane_t x, input logic relu, input int unsigned sh);
        lane_t y;
        y = (relu && (x < 0)) ? '0 : x;
        return y >>> sh;
    endfunction

endpackage

// File: rtl/dnn_writeback_if.sv
// Valid/ready write port towards the node-feature memory.
interface dnn_writeback_if #(
    parameter int unsigned ADDR_W = 8
) ();
    import gnn_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    vec4_t             wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/wb_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is taken only when a
// pop happens in the same cycle.
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Head is forced to zero when empty so the write port idles at zero.
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    // Storage array; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/dnn_writeback.sv
// Collects activated output beats from the dnn engine and writes one 4-lane
// word per node to memory, buffering through a small FIFO.
module dnn_writeback
    import gnn_pkg::*;
#(
    parameter int unsigned MAX_NODES  = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SHIFT      = 0,
    parameter int unsigned RELU_EN    = 1,
    localparam int unsigned ADDR_W    = $clog2(MAX_NODES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W:0]   num_nodes_i,
    input  logic              out_ready_i,
    input  lane_t             out0_i,
    input  lane_t             out1_i,
    input  lane_t             out2_i,
    input  lane_t             out3_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    dnn_writeback_if.master   wr
);

    localparam int unsigned ENTRY_W = ADDR_W + 4 * DATA_W;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    wb_state_e          state_q;
    logic [ADDR_W:0]    num_q;
    logic [ADDR_W:0]    acc_q;
    logic [ADDR_W:0]    acc_inc;
    logic               busy_q, done_q, ovf_q;

    vec4_t              act_vec;
    logic               beat, pop, flush, drop, drain_done;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [ENTRY_W-1:0] head;

    // Per-lane activation ahead of the FIFO.
    always_comb begin
        act_vec    = '0;
        act_vec[0] = wb_act(out0_i, RELU_EN != 0, SHIFT);
        act_vec[1] = wb_act(out1_i, RELU_EN != 0, SHIFT);
        act_vec[2] = wb_act(out2_i, RELU_EN != 0, SHIFT);
        act_vec[3] = wb_act(out3_i, RELU_EN != 0, SHIFT);
    end

    assign beat    = (state_q == StCollect) && out_ready_i;
    assign pop     = wr.wr_valid && wr.wr_ready;
    assign flush   = (state_q == StIdle) && start_i;
    assign drop    = beat && fifo_full && !pop;
    assign acc_inc = acc_q + (ADDR_W + 1)'(1);
    // Finish on the edge that retires the last entry so done follows it by one cycle.
    assign drain_done = fifo_empty || (pop && (fifo_cnt == CNT_W'(1)));

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (beat),
        .pop_i   (pop),
        .wdata_i ({acc_q[ADDR_W-1:0], act_vec}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign wr.wr_valid = !fifo_empty;
    assign wr.wr_addr  = head[ENTRY_W-1 -: ADDR_W];
    assign wr.wr_data  = head[4*DATA_W-1:0];

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = ovf_q;

    // Pass sequencing, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            num_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        num_q <= num_nodes_i;
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                        if (num_nodes_i == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StCollect;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StCollect: begin
                    if (beat) begin
                        acc_q <= acc_inc;
                        if (drop) ovf_q <= 1'b1;
                        if (acc_inc == num_q) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
